// File: rtl/bist_pkg.sv
// Shared types and the march data patterns for the memory BIST controller.
package bist_pkg;
  typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {ZERO, ADDR, CKBD} phase_t;

  localparam int          PAT_W     = 8;
  localparam logic [7:0]  CKBD_EVEN = 8'h55;
  localparam logic [7:0]  CKBD_ODD  = 8'hAA;

  function automatic logic [PAT_W-1:0] pattern(input phase_t ph, input logic [PAT_W-1:0] a);
    case (ph)
      ADDR:    return a;
      CKBD:    return a[0] ? CKBD_ODD : CKBD_EVEN;
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/bist_checker.sv
// Read-return checker: delays {valid,addr} by READ_LAT, compares returned data
// against the phase pattern, keeps a saturating error count and first-fail capture.
module bist_checker
  import bist_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1,
  parameter int ERR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_flush,
  input  logic              i_vld,
  input  logic [ADDR_W-1:0] i_addr,
  input  phase_t            i_phase,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [ERR_W-1:0]  o_err_count,
  output logic              o_fail_valid,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [DATA_W-1:0] o_fail_data
);
  logic [READ_LAT:1]             r_vld_pipe;
  logic [READ_LAT:1][ADDR_W-1:0] r_addr_pipe;
  logic [ERR_W-1:0]              r_err;
  logic                          r_fail_valid;
  logic [ADDR_W-1:0]             r_fail_addr;
  logic [DATA_W-1:0]             r_fail_data;
  logic [DATA_W-1:0]             w_exp;
  logic                          w_mis;

  assign w_exp = DATA_W'(pattern(i_phase, PAT_W'(r_addr_pipe[READ_LAT])));
  assign w_mis = r_vld_pipe[READ_LAT] && (i_rdata != w_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_addr_pipe <= '0;
    end else begin
      r_vld_pipe[1]  <= i_vld && !i_clear && !i_flush;
      r_addr_pipe[1] <= i_addr;
      for (int k = 2; k <= READ_LAT; k++) begin
        r_vld_pipe[k]  <= r_vld_pipe[k-1] && !i_clear && !i_flush;
        r_addr_pipe[k] <= r_addr_pipe[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_addr  <= '0;
      r_fail_data  <= '0;
    end else if (i_clear) begin
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_addr  <= '0;
      r_fail_data  <= '0;
    end else if (w_mis) begin
      if (r_err != {ERR_W{1'b1}}) r_err <= r_err + ERR_W'(1);
      if (!r_fail_valid) begin
        r_fail_valid <= 1'b1;
        r_fail_addr  <= r_addr_pipe[READ_LAT];
        r_fail_data  <= i_rdata;
      end
    end
  end

  assign o_err_count  = r_err;
  assign o_fail_valid = r_fail_valid;
  assign o_fail_addr  = r_fail_addr;
  assign o_fail_data  = r_fail_data;
endmodule

// File: rtl/mem_bist_ctrl.sv
// March BIST controller: ZERO, ADDR and CKBD phases, each a full write sweep,
// a full read sweep and a drain; results come from bist_checker.
module mem_bist_ctrl
  import bist_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1,
  parameter int ERR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              fail_valid,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);
  localparam int LW = $clog2(READ_LAT + 1);

  state_t            r_state, w_nxt_state;
  phase_t            r_phase, w_nxt_phase;
  logic [ADDR_W-1:0] r_addr,  w_nxt_addr;
  logic [LW-1:0]     r_drain, w_nxt_drain;
  logic              w_start_acc, w_flush, w_last;
  logic [DATA_W-1:0] w_pat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_phase <= ZERO;
      r_addr  <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_phase <= w_nxt_phase;
      r_addr  <= w_nxt_addr;
      r_drain <= w_nxt_drain;
    end
  end

  assign w_last = &r_addr;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_phase = r_phase;
    w_nxt_addr  = r_addr;
    w_nxt_drain = r_drain;
    w_start_acc = 1'b0;
    w_flush     = 1'b0;
    if (abort && r_state != IDLE) begin
      w_nxt_state = IDLE;
      w_nxt_phase = ZERO;
      w_nxt_addr  = '0;
      w_nxt_drain = '0;
      w_flush     = 1'b1;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) begin
          w_nxt_state = WR;
          w_nxt_phase = ZERO;
          w_nxt_addr  = '0;
          w_start_acc = 1'b1;
        end
        // the address counter only wraps on the last beat, together with the state change
        WR: begin
          w_nxt_addr = r_addr + ADDR_W'(1);
          if (w_last) w_nxt_state = RD;
        end
        RD: begin
          w_nxt_addr = r_addr + ADDR_W'(1);
          if (w_last) begin
            w_nxt_state = DRAIN;
            w_nxt_drain = '0;
          end
        end
        DRAIN: begin
          if (r_drain == LW'(READ_LAT - 1)) begin
            w_nxt_drain = '0;
            case (r_phase)
              ZERO:    begin w_nxt_phase = ADDR; w_nxt_state = WR; end
              ADDR:    begin w_nxt_phase = CKBD; w_nxt_state = WR; end
              default: w_nxt_state = DONE;
            endcase
          end else begin
            w_nxt_drain = r_drain + LW'(1);
          end
        end
        default: w_nxt_state = IDLE;
      endcase
    end
  end

  assign w_pat   = DATA_W'(pattern(r_phase, PAT_W'(r_addr)));
  assign write   = (r_state == WR);
  assign read    = (r_state == RD);
  assign addr    = (write || read) ? r_addr : '0;
  assign data_in = write ? w_pat : '0;
  assign busy    = (r_state == WR) || (r_state == RD) || (r_state == DRAIN);
  assign done    = (r_state == DONE);
  assign pass    = done && (err_count == '0);

  bist_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .ERR_W(ERR_W)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_start_acc),
    .i_flush     (w_flush),
    .i_vld       (read),
    .i_addr      (r_addr),
    .i_phase     (r_phase),
    .i_rdata     (data_out),
    .o_err_count (err_count),
    .o_fail_valid(fail_valid),
    .o_fail_addr (fail_addr),
    .o_fail_data (fail_data)
  );
endmodule
